// File: rtl/serial_tx_scheduler.sv
// Round-robin front end that shares one serial transmitter between NUM_REQ byte
// requesters, tracks each frame to completion or timeout and enforces an idle gap.
module serial_tx_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int IDW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic [NUM_REQ-1:0]   cmpl,
    output logic                 cmpl_err,
    output logic                 active,
    output logic [IDW-1:0]       grant_id,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    input  logic                 tx_done
);

    localparam int                 TOW     = $clog2(TIMEOUT_CYCLES);
    localparam logic [TOW-1:0]     TO_LAST = TOW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]         GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic               NO_GAP  = (GAP_CYCLES == 0) ? 1'b1 : 1'b0;
    localparam logic [IDW-1:0]     LAST_ID = IDW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_ID  = NUM_REQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [IDW-1:0]     rr_ptr_r, rr_ptr_s;
    logic [TOW-1:0]     to_cnt_r, to_cnt_s;
    logic [7:0]         gap_cnt_r, gap_cnt_s;
    logic [NUM_REQ-1:0] ack_r, ack_s;
    logic [NUM_REQ-1:0] cmpl_r, cmpl_s;
    logic               cmpl_err_r, cmpl_err_s;
    logic               active_r, active_s;
    logic [IDW-1:0]     grant_id_r, grant_id_s;
    logic               tx_start_r, tx_start_s;
    logic [7:0]         tx_data_r, tx_data_s;

    logic [IDW-1:0]     cand_s;
    logic [IDW-1:0]     win_s;
    logic               found_s;

    // Round-robin search: first set request at or above rr_ptr, wrapping to 0.
    always_comb begin
        cand_s  = '0;
        win_s   = '0;
        found_s = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            cand_s = IDW'((int'(rr_ptr_r) + j) % NUM_REQ);
            if (!found_s && req[cand_s]) begin
                found_s = 1'b1;
                win_s   = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and registered-output logic for the grant/track/gap sequence.
    always_comb begin
        state_s    = state_r;
        rr_ptr_s   = rr_ptr_r;
        to_cnt_s   = to_cnt_r;
        gap_cnt_s  = gap_cnt_r;
        ack_s      = '0;
        cmpl_s     = '0;
        cmpl_err_s = 1'b0;
        active_s   = active_r;
        grant_id_s = grant_id_r;
        tx_start_s = 1'b0;
        tx_data_s  = tx_data_r;

        case (state_r)
            ST_IDLE: begin
                if (!tx_busy && found_s) begin
                    tx_data_s  = req_data[{win_s, 3'b000} +: 8];
                    grant_id_s = win_s;
                    ack_s      = ONE_ID << win_s;
                    tx_start_s = 1'b1;
                    active_s   = 1'b1;
                    to_cnt_s   = '0;
                    rr_ptr_s   = (win_s == LAST_ID) ? '0 : win_s + IDW'(1);
                    state_s    = ST_LAUNCH;
                end else begin
                    active_s = 1'b0;
                end
            end
            ST_LAUNCH, ST_WAIT: begin
                // A done still high from the previous frame only counts once busy was seen.
                if ((state_r == ST_WAIT) && tx_done && !tx_busy) begin
                    cmpl_s     = ONE_ID << grant_id_r;
                    cmpl_err_s = 1'b0;
                    gap_cnt_s  = '0;
                    if (NO_GAP) begin
                        state_s  = ST_IDLE;
                        active_s = 1'b0;
                    end else begin
                        state_s = ST_GAP;
                    end
                end else if (to_cnt_r == TO_LAST) begin
                    cmpl_s     = ONE_ID << grant_id_r;
                    cmpl_err_s = 1'b1;
                    gap_cnt_s  = '0;
                    if (NO_GAP) begin
                        state_s  = ST_IDLE;
                        active_s = 1'b0;
                    end else begin
                        state_s = ST_GAP;
                    end
                end else begin
                    to_cnt_s = to_cnt_r + TOW'(1);
                    if (tx_busy) begin
                        state_s = ST_WAIT;
                    end else begin
                        state_s = state_r;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_s  = ST_IDLE;
                    active_s = 1'b0;
                end else begin
                    gap_cnt_s = gap_cnt_r + 8'd1;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                active_s = 1'b0;
            end
        endcase
    end

    // State, counters and outputs; reset aborts any frame without a completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= '0;
            to_cnt_r   <= '0;
            gap_cnt_r  <= 8'd0;
            ack_r      <= '0;
            cmpl_r     <= '0;
            cmpl_err_r <= 1'b0;
            active_r   <= 1'b0;
            grant_id_r <= '0;
            tx_start_r <= 1'b0;
            tx_data_r  <= 8'd0;
        end else begin
            state_r    <= state_s;
            rr_ptr_r   <= rr_ptr_s;
            to_cnt_r   <= to_cnt_s;
            gap_cnt_r  <= gap_cnt_s;
            ack_r      <= ack_s;
            cmpl_r     <= cmpl_s;
            cmpl_err_r <= cmpl_err_s;
            active_r   <= active_s;
            grant_id_r <= grant_id_s;
            tx_start_r <= tx_start_s;
            tx_data_r  <= tx_data_s;
        end
    end

    assign ack      = ack_r;
    assign cmpl     = cmpl_r;
    assign cmpl_err = cmpl_err_r;
    assign active   = active_r;
    assign grant_id = grant_id_r;
    assign tx_start = tx_start_r;
    assign tx_data  = tx_data_r;

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Bench for serial_tx_scheduler: behavioural transmitter, start/completion
// scoreboard, a vector table of single grants and hand-written corner sequences.
module tb_serial_tx_scheduler;

    localparam int GAP  = 2;
    localparam int TOUT = 16;
    localparam int FRAME = 5;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } start_t;

    typedef struct packed {
        logic [1:0] id;
        logic       err;
    } cmpl_t;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        int          exp_id;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = 4'b0000;
    logic [31:0] req_data = 32'h0;
    logic [3:0]  ack;
    logic [3:0]  cmpl;
    logic        cmpl_err;
    logic        active;
    logic [1:0]  grant_id;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        tx_done;

    logic busy_m = 1'b0;
    logic done_m = 1'b0;
    int   cnt_m = 0;
    int   dly_m = 0;
    bit   dead = 1'b0;
    bit   hold_busy = 1'b0;
    int   start_delay = 0;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    start_t start_q[$];
    cmpl_t  cmpl_q[$];
    vec_t   vecs[6];

    assign tx_busy = busy_m | hold_busy;
    assign tx_done = done_m;

    serial_tx_scheduler #(
        .NUM_REQ(4),
        .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .req_data(req_data),
        .ack(ack),
        .cmpl(cmpl),
        .cmpl_err(cmpl_err),
        .active(active),
        .grant_id(grant_id),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_busy(tx_busy),
        .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    // Transmitter model: optional busy delay after start, done held until the next start.
    always @(posedge clk) begin
        if (tx_start) begin
            if (!dead) begin
                if (start_delay == 0) begin
                    busy_m <= 1'b1;
                    done_m <= 1'b0;
                    cnt_m  <= FRAME;
                end else begin
                    dly_m <= start_delay;
                end
            end
        end else if (dly_m > 0) begin
            if (dly_m == 1) begin
                busy_m <= 1'b1;
                done_m <= 1'b0;
                cnt_m  <= FRAME;
            end
            dly_m <= dly_m - 1;
        end else if (busy_m) begin
            if (cnt_m == 1) begin
                busy_m <= 1'b0;
                done_m <= 1'b1;
            end
            cnt_m <= cnt_m - 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_event(input string name, input logic [31:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: observed %0h where none was expected (cycle %0d)", name, act, cyc);
    endtask

    // Advance to the next falling edge and score any start/completion pulses.
    task automatic tick();
        start_t     s;
        cmpl_t      c;
        logic [3:0] oh;
        @(negedge clk);
        cyc++;
        if (rst_n) begin
            if (tx_start) begin
                if (start_q.size() == 0) begin
                    fail_event("unexpected_start", 32'(tx_data));
                end else begin
                    s  = start_q.pop_front();
                    oh = 4'b0001 << s.id;
                    check("sb_start_id", 32'(grant_id), 32'(s.id));
                    check("sb_start_data", 32'(tx_data), 32'(s.data));
                    check("sb_start_ack", 32'(ack), 32'(oh));
                end
            end
            if (cmpl != 4'b0000) begin
                if (cmpl_q.size() == 0) begin
                    fail_event("unexpected_cmpl", 32'(cmpl));
                end else begin
                    c  = cmpl_q.pop_front();
                    oh = 4'b0001 << c.id;
                    check("sb_cmpl_onehot", 32'(cmpl), 32'(oh));
                    check("sb_cmpl_err", 32'(cmpl_err), 32'(c.err));
                end
            end
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!active && !tx_busy && cmpl_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) fail_event("wait_idle_timeout", 32'(active));
    endtask

    task automatic push_frame(input int id, input logic [7:0] b, input logic err);
        start_t s;
        cmpl_t  c;
        s.id = 2'(id); s.data = b;
        c.id = 2'(id); c.err = err;
        start_q.push_back(s);
        cmpl_q.push_back(c);
    endtask

    // One grant from an idle scheduler, checking latency, pulse widths and completion timing.
    task automatic do_single(input logic [3:0] r, input logic [31:0] d, input int id);
        logic [3:0] oh;
        logic [7:0] b;
        int         early;
        bit         ok;
        oh = 4'b0001 << id;
        b  = d[8*id +: 8];
        wait_idle();
        push_frame(id, b, 1'b0);
        req = r;
        req_data = d;
        tick();
        check("ack_latency", 32'(ack), 32'(oh));
        check("start_pulse", 32'(tx_start), 32'h1);
        check("active_on", 32'(active), 32'h1);
        check("grant_id", 32'(grant_id), 32'(id));
        check("tx_data", 32'(tx_data), 32'(b));
        req = 4'b0000;
        req_data = 32'h0;
        tick();
        check("ack_start_width", 32'({ack, tx_start}), 32'h0);
        check("tx_data_hold", 32'(tx_data), 32'(b));
        early = 0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (tx_busy) begin
                ok = 1'b1;
                break;
            end
            if (cmpl != 4'b0000) early++;
            tick();
        end
        if (!ok) fail_event("busy_never_rose", 32'(tx_busy));
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (tx_done && !tx_busy) begin
                ok = 1'b1;
                break;
            end
            if (cmpl != 4'b0000) early++;
            tick();
        end
        if (!ok) fail_event("done_never_seen", 32'(tx_done));
        if (cmpl != 4'b0000) early++;
        tick();
        check("cmpl_latency", 32'(cmpl), 32'(oh));
        check("cmpl_err_clear", 32'(cmpl_err), 32'h0);
        check("no_early_cmpl", 32'(early), 32'h0);
    endtask

    initial begin
        int         nc, n0, n, t0, last_c;
        bit         have_c, found;

        vecs[0] = '{req: 4'b0010, data: 32'h1234A578, exp_id: 1};
        vecs[1] = '{req: 4'b1001, data: 32'hC3000096, exp_id: 3};
        vecs[2] = '{req: 4'b1001, data: 32'h5A0000E1, exp_id: 0};
        vecs[3] = '{req: 4'b0101, data: 32'h00F0000F, exp_id: 2};
        vecs[4] = '{req: 4'b0011, data: 32'h00007E81, exp_id: 0};
        vecs[5] = '{req: 4'b1000, data: 32'hFF000000, exp_id: 3};

        for (int i = 0; i < 3; i++) tick();
        check("reset_outputs", 32'({ack, cmpl, cmpl_err, active, grant_id, tx_start, tx_data}), 32'h0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) do_single(vecs[i].req, vecs[i].data, vecs[i].exp_id);

        // All four at once: strict order 0..3, exact gap between cmpl and the next start.
        wait_idle();
        for (int i = 0; i < 4; i++) push_frame(i, 8'(8'h11 * (i + 1)), 1'b0);
        req_data = 32'h44332211;
        req = 4'b1111;
        nc = 0; have_c = 1'b0; last_c = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (tx_start && have_c) check("gap_to_next_start", 32'(cyc - last_c), 32'(GAP + 1));
            if (ack != 4'b0000) req = req & ~ack;
            if (cmpl != 4'b0000) begin
                last_c = cyc;
                have_c = 1'b1;
                nc++;
            end
            if (nc == 4) break;
        end
        check("all_four_done", 32'(nc), 32'h4);
        do_single(4'b1111, 32'h0D0C0B0A, 0);

        // Fairness: req0 held high, req2 arrives during req0's frame.
        wait_idle();
        push_frame(0, 8'hAA, 1'b0);
        push_frame(2, 8'hBB, 1'b0);
        push_frame(0, 8'hAA, 1'b0);
        req_data = 32'h00BB00AA;
        req = 4'b0001;
        nc = 0; n0 = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (ack[0]) begin
                n0++;
                if (n0 == 1) req[2] = 1'b1;
                else req[0] = 1'b0;
            end
            if (ack[2]) req[2] = 1'b0;
            if (cmpl != 4'b0000) nc++;
            if (nc == 3) break;
        end
        check("fair_cmpls", 32'(nc), 32'h3);

        // Stale done from the previous frame while busy is slow to rise.
        start_delay = 4;
        do_single(4'b0100, 32'h005C0000, 2);
        start_delay = 0;

        // Timeout with a transmitter that never goes busy, then busy held high.
        wait_idle();
        dead = 1'b1;
        start_q.push_back(start_t'{id: 2'd2, data: 8'h9D});
        cmpl_q.push_back(cmpl_t'{id: 2'd2, err: 1'b1});
        req_data = 32'h009D0000;
        req = 4'b0100;
        tick();
        check("timeout_ack", 32'(ack), 32'h4);
        t0 = cyc;
        req = 4'b0000;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (cmpl != 4'b0000) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) fail_event("timeout_cmpl_missing", 32'(cmpl));
        else check("timeout_latency", 32'(cyc - t0), 32'(TOUT));
        check("timeout_err", 32'(cmpl_err), 32'h1);
        hold_busy = 1'b1;
        req_data = 32'h000000C7;
        req = 4'b0001;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx_start) n++;
        end
        check("no_start_while_busy", 32'(n), 32'h0);
        dead = 1'b0;
        push_frame(0, 8'hC7, 1'b0);
        hold_busy = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n++;
            if (ack != 4'b0000) break;
        end
        check("grant_after_busy_drop", 32'(n), 32'h1);
        req = 4'b0000;

        // Reset during WAIT: silent abort, round-robin restarts at 0.
        wait_idle();
        start_q.push_back(start_t'{id: 2'd1, data: 8'h66});
        req_data = 32'h00006600;
        req = 4'b0010;
        tick();
        req = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            if (tx_busy) break;
            tick();
        end
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("reset_mid_outputs", 32'({ack, cmpl, cmpl_err, active, grant_id, tx_start, tx_data}), 32'h0);
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b1;
        do_single(4'b1111, 32'h77665544, 0);
        wait_idle();
        check("scoreboard_drained", 32'(start_q.size() + cmpl_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule
